hex_token_to_word: RTL and testbench

//  Streaming ASCII-hex parser: takes one trace-file character per cycle and assembles

---
 rtl/hex_parse_pkg.sv | 24 ++
 rtl/hex_char_decode.sv | 30 +++
 rtl/hex_token_to_word.sv | 152 +++++++++++++++
 tb/tb_hex_token_to_word.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_parse_pkg.sv
// hex_parse_pkg
//   Shared types and constants for the streaming ASCII-hex token parser.
//   - state_t      : parser FSM states
//   - char_class_t : classification of an incoming character
//   - CH_SPACE/CH_LF/CH_CR : token terminator characters
package hex_parse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIGIT = 2'd0,
    TERM  = 2'd1,
    BAD   = 2'd2
  } char_class_t;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

endpackage

// File: rtl/hex_char_decode.sv
// hex_char_decode
//   Combinational classifier for one ASCII character.
//   Ports:
//     ch  in  8  ASCII character
//     cls out    DIGIT ('0'-'9','a'-'f','A'-'F'), TERM (space/LF/CR) or BAD
//     nib out 4  nibble value of a DIGIT, 0 otherwise
module hex_char_decode
  import hex_parse_pkg::*;
(
  input  logic [7:0]  ch,
  output char_class_t cls,
  output logic [3:0]  nib
);

  always_comb begin
    cls = BAD;
    nib = 4'h0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      cls = DIGIT;
      nib = ch[3:0];
    end else if ((ch >= 8'h61 && ch <= 8'h66) || (ch >= 8'h41 && ch <= 8'h46)) begin
      // 'a'/'A' have low nibble 1, so adding 9 maps them onto 10..15
      cls = DIGIT;
      nib = ch[3:0] + 4'd9;
    end else if (ch == CH_SPACE || ch == CH_LF || ch == CH_CR) begin
      cls = TERM;
    end
  end

endmodule

// File: rtl/hex_token_to_word.sv
// hex_token_to_word
//   Streaming ASCII-hex parser. Accepts one character per cycle and assembles
//   whitespace-delimited hex tokens into 4*NIBBLES-bit words. Tokens longer than
//   NIBBLES digits keep their least-significant digits and are flagged; bad
//   characters are skipped and flag the token.
//   Optional macro HEX_PARSE_ERRCNT_EN adds err_count (errored words emitted,
//   saturating) and its CNT_W parameter.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     in_valid/in_ready    character handshake (in_ready = !out_valid)
//     in_char              ASCII character
//     out_valid/out_ready  word handshake
//     out_word             parsed value, zero-extended
//     out_nibbles          digits kept (saturates at NIBBLES)
//     out_err              token held a bad char or overflowed
//     err_count            (HEX_PARSE_ERRCNT_EN) errored words handed off
//
//   state | meaning
//   ------+-------------------------------------------
//   IDLE  | no token open, whitespace is swallowed
//   ACCUM | token open, digits shift into acc
//   HOLD  | word registered on out_*, waiting for out_ready
module hex_token_to_word
  import hex_parse_pkg::*;
#(
  parameter int NIBBLES = 8
`ifdef HEX_PARSE_ERRCNT_EN
  ,
  parameter int CNT_W   = 16
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [7:0]                     in_char,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [4*NIBBLES-1:0]           out_word,
  output logic [$clog2(NIBBLES+1)-1:0]   out_nibbles,
  output logic                           out_err
`ifdef HEX_PARSE_ERRCNT_EN
  ,
  output logic [CNT_W-1:0]               err_count
`endif
);

  localparam int OUT_W = 4 * NIBBLES;
  localparam int NW    = $clog2(NIBBLES + 1);

  state_t            state;
  logic [OUT_W-1:0]  acc;
  logic [NW-1:0]     cnt;
  logic              err;

  char_class_t       cls;
  logic [3:0]        nib;
  logic [OUT_W-1:0]  acc_shift;
  logic              take;

  hex_char_decode u_dec (
    .ch  (in_char),
    .cls (cls),
    .nib (nib)
  );

  // Forced high in reset so the upstream reader never stalls against a
  // word that reset is about to discard.
  assign in_ready = rst | ~out_valid;
  assign take     = in_valid & in_ready;

  generate
    if (NIBBLES == 1) begin : g_shift1
      assign acc_shift = nib;
    end else begin : g_shiftn
      assign acc_shift = {acc[OUT_W-5:0], nib};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      out_valid   <= 1'b0;
      out_word    <= '0;
      out_nibbles <= '0;
      out_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            case (cls)
              DIGIT: begin
                acc   <= OUT_W'(nib);
                cnt   <= NW'(1);
                err   <= 1'b0;
                state <= ACCUM;
              end
              BAD: begin
                acc   <= '0;
                cnt   <= '0;
                err   <= 1'b1;
                state <= ACCUM;
              end
              default: ;
            endcase
          end
        end
        ACCUM: begin
          if (take) begin
            case (cls)
              DIGIT: begin
                acc <= acc_shift;
                if (cnt == NW'(NIBBLES)) err <= 1'b1;
                else                     cnt <= cnt + NW'(1);
              end
              BAD: err <= 1'b1;
              TERM: begin
                out_word    <= acc;
                out_nibbles <= cnt;
                out_err     <= err;
                out_valid   <= 1'b1;
                state       <= HOLD;
              end
              default: ;
            endcase
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HEX_PARSE_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_err && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hex_token_to_word.sv
module tb_hex_token_to_word;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [7:0]  in_char;
  logic [31:0] out_word;
  logic [3:0]  out_nibbles;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_err1;
  logic [7:0]  in_char1;
  logic [3:0]  out_word1;
  logic [0:0]  out_nibbles1;

`ifdef HEX_PARSE_ERRCNT_EN
  logic [15:0] err_count, err_count1;
`endif

  typedef struct {
    logic [31:0] w;
    int          nb;
    bit          e;
  } item_t;

  item_t got0[$];
  item_t got1[$];
  item_t exp0[$];
  item_t exp1[$];

  int total = 0;
  int bad   = 0;
  int ec_idx = 0;

  always #5 clk = ~clk;

  hex_token_to_word #(.NIBBLES(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_nibbles(out_nibbles), .out_err(out_err)
`ifdef HEX_PARSE_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  hex_token_to_word #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_char(in_char1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_word(out_word1), .out_nibbles(out_nibbles1), .out_err(out_err1)
`ifdef HEX_PARSE_ERRCNT_EN
    , .err_count(err_count1)
`endif
  );

  // Collect every word handed off by each DUT.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      got0.push_back('{w: out_word, nb: int'(out_nibbles), e: out_err});
    if (!rst && out_valid1 && out_ready1)
      got1.push_back('{w: {28'h0, out_word1}, nb: int'(out_nibbles1), e: out_err1});
  end

  function automatic int digit_val(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  // Reference: split on whitespace; value = last n digits, err = bad char or too many digits.
  task automatic model(input string s, input int n, input int which);
    bit     open = 0;
    int     cnt  = 0;
    bit     er   = 0;
    longint val  = 0;
    longint modv = longint'(1) << (4 * n);
    logic [7:0] c;
    int     d;
    item_t  it;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      d = digit_val(c);
      if (c == 8'h20 || c == 8'h0A || c == 8'h0D) begin
        if (open) begin
          it.w  = 32'(val);
          it.nb = (cnt > n) ? n : cnt;
          it.e  = er || (cnt > n);
          if (which == 0) exp0.push_back(it); else exp1.push_back(it);
        end
        open = 0;
      end else begin
        if (!open) begin
          open = 1; cnt = 0; er = 0; val = 0;
        end
        if (d >= 0) begin
          val = (val * 16 + longint'(d)) % modv;
          cnt++;
        end else begin
          er = 1;
        end
      end
    end
  endtask

  function automatic int got_size(input int which);
    return (which == 0) ? got0.size() : got1.size();
  endfunction

  function automatic item_t got_at(input int which, input int i);
    return (which == 0) ? got0[i] : got1[i];
  endfunction

  function automatic int exp_size(input int which);
    return (which == 0) ? exp0.size() : exp1.size();
  endfunction

  function automatic item_t exp_at(input int which, input int i);
    return (which == 0) ? exp0[i] : exp1[i];
  endfunction

  task automatic put_char(input logic [7:0] c, input int which);
    int budget = 0;
    bit acc = 0;
    if (which == 0) begin in_valid = 1'b1; in_char = c; end
    else            begin in_valid1 = 1'b1; in_char1 = c; end
    do begin
      @(negedge clk);
      acc = (which == 0) ? in_ready : in_ready1;
      @(posedge clk);
      #1;
      budget++;
    end while (!acc && budget < 200);
    if (which == 0) in_valid = 1'b0; else in_valid1 = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL put_char_timeout: char=%02h accepted=%0d required=1", c, acc);
    end
  endtask

  task automatic send(input string s, input int which, input int gap_max);
    for (int i = 0; i < s.len(); i++) begin
      put_char(s[i], which);
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic check_words(input string name, input int which, input int gbase, input int ebase);
    int want = exp_size(which) - ebase;
    int k = 0;
    item_t g, e;
    while (got_size(which) - gbase < want && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (got_size(which) - gbase !== want) begin
      bad++;
      $display("FAIL %s_count: got=%0d words required=%0d", name, got_size(which) - gbase, want);
    end
    for (int i = 0; i < want && gbase + i < got_size(which); i++) begin
      g = got_at(which, gbase + i);
      e = exp_at(which, ebase + i);
      total++;
      if (g.w !== e.w || g.nb !== e.nb || g.e !== e.e) begin
        bad++;
        $display("FAIL %s_word%0d: got w=%08h nb=%0d err=%0d required w=%08h nb=%0d err=%0d",
                 name, i, g.w, g.nb, g.e, e.w, e.nb, e.e);
      end
    end
  endtask

`ifdef HEX_PARSE_ERRCNT_EN
  task automatic check_errcnt(input string name);
    int want = 0;
    for (int i = ec_idx; i < exp0.size(); i++) if (exp0[i].e) want++;
    total++;
    if (err_count !== 16'(want)) begin
      bad++;
      $display("FAIL %s_errcnt: got=%0d required=%0d", name, err_count, want);
    end
  endtask
`endif

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; in_char = "5";
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_word !== 32'h0 || out_nibbles !== 4'h0 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%0d w=%08h nb=%0d e=%0d required 0/0/0/0",
               out_valid, out_word, out_nibbles, out_err);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got=%0d required=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    // a '5' sampled during reset would surface as a word on this terminator
    begin
      int gb = got0.size();
      int eb = exp0.size();
      send(" ", 0, 0);
      check_words("reset_ignore", 0, gb, eb);
    end
  endtask

  task automatic test_basic();
    int gb = got0.size();
    int eb = exp0.size();
    out_ready = 1'b1;
    model("1A2b ", 8, 0);
    send("1A2b", 0, 0);
    put_char(" ", 0);
    total++;
    if (out_valid !== 1'b1 || out_word !== 32'h00001A2B || out_nibbles !== 4'd4 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL basic_latency: got v=%0d w=%08h nb=%0d e=%0d required 1/00001a2b/4/0",
               out_valid, out_word, out_nibbles, out_err);
    end
    check_words("basic", 0, gb, eb);
  endtask

  task automatic test_whitespace();
    int gb = got0.size();
    int eb = exp0.size();
    model("   ff\n\015\n", 8, 0);
    send("   ff\n\015\n", 0, 1);
    check_words("whitespace", 0, gb, eb);
    total++;
    if (got_size(0) != gb + 1 || got0[gb].w !== 32'h000000FF || got0[gb].nb !== 2) begin
      bad++;
      $display("FAIL whitespace_ff: got words=%0d required one word 000000ff nb=2", got_size(0) - gb);
    end
  endtask

  task automatic test_overflow();
    int gb = got0.size();
    int eb = exp0.size();
    model("123456789 ", 8, 0);
    send("123456789 ", 0, 0);
    check_words("overflow", 0, gb, eb);
  endtask

  task automatic test_bad_char();
    int gb = got0.size();
    int eb = exp0.size();
    model("12G4 ", 8, 0);
    send("12G4 ", 0, 0);
    check_words("badchar", 0, gb, eb);
`ifdef HEX_PARSE_ERRCNT_EN
    check_errcnt("badchar");
`endif
  endtask

  task automatic test_back_to_back_hold();
    int gb = got0.size();
    int eb = exp0.size();
    out_ready = 1'b0;
    model("7 8 ", 8, 0);
    fork
      send("7 8 ", 0, 0);
      begin
        int k = 0;
        while (!out_valid && k < 100) begin
          @(negedge clk);
          k++;
        end
        for (int c = 0; c < 5; c++) begin
          total++;
          if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_word !== 32'h7) begin
            bad++;
            $display("FAIL hold_cycle%0d: got v=%0d rdy=%0d w=%08h required 1/0/00000007",
                     c, out_valid, in_ready, out_word);
          end
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check_words("hold", 0, gb, eb);
  endtask

  task automatic test_nibbles1();
    int gb = got1.size();
    int eb = exp1.size();
    model("F ", 1, 1);
    send("F ", 1, 0);
    check_words("nib1_f", 1, gb, eb);
    total++;
    if (got_size(1) <= gb || got1[gb].w !== 32'hF) begin
      bad++;
      $display("FAIL nib1_value: got words=%0d required word f", got_size(1) - gb);
    end
    gb = got1.size();
    eb = exp1.size();
    model("A5 0 x3  c\n", 1, 1);
    send("A5 0 x3  c\n", 1, 1);
    check_words("nib1_mix", 1, gb, eb);
  endtask

  task automatic test_mid_reset();
    int gb, eb;
    send("AB", 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ec_idx = exp0.size();
    gb = got0.size();
    eb = exp0.size();
    model("C ", 8, 0);
    send("C ", 0, 0);
    check_words("midreset", 0, gb, eb);
    // reset while a word is held
    gb = got0.size();
    eb = exp0.size();
    out_ready = 1'b0;
    send("9 ", 0, 0);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL holdreset_in_ready: got=%0d required=1", in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ec_idx = exp0.size();
    total++;
    if (out_valid !== 1'b0 || out_word !== 32'h0 || out_nibbles !== 4'h0 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL holdreset_outputs: got v=%0d w=%08h nb=%0d e=%0d required 0/0/0/0",
               out_valid, out_word, out_nibbles, out_err);
    end
    out_ready = 1'b1;
    check_words("holdreset", 0, gb, eb);
  endtask

  task automatic test_random();
    string pool;
    string s;
    logic [7:0] ch;
    int gb, eb, len;
    bit done;
    pool = "0123456789abcdefABCDEFxyzG!   \n\015";
    for (int it = 0; it < 6; it++) begin
      s = "";
      len = $urandom_range(10, 30);
      for (int i = 0; i < len; i++) begin
        ch = pool[$urandom_range(0, pool.len() - 1)];
        s = {s, string'(ch)};
      end
      s = {s, " "};
      gb = got0.size();
      eb = exp0.size();
      model(s, 8, 0);
      done = 0;
      fork
        begin
          send(s, 0, 2);
          done = 1;
        end
        begin
          while (!done) begin
            @(posedge clk);
            #2;
            out_ready = 1'($urandom_range(0, 1));
          end
          out_ready = 1'b1;
        end
      join
      check_words("random", 0, gb, eb);
    end
`ifdef HEX_PARSE_ERRCNT_EN
    check_errcnt("random");
`endif
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_char = 8'h0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_char1 = 8'h0; out_ready1 = 1'b1;
    test_reset();
    test_basic();
    test_whitespace();
    test_overflow();
    test_bad_char();
    test_back_to_back_hold();
    test_nibbles1();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
